// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, the canonical NOP and the fetch FSM encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_ERR  = 2'd2
  } fetch_state_e;

  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux (jump > taken branch > pc+4) with target alignment mask or check.
// FETCH_MISALIGN_CHK_EN: flag misaligned targets instead of masking their low bits.
module pc_next_sel
  import riscv_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        jump_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        target_sel;

  assign seq_pc = pc_i + 32'd4;

  always_comb begin
    target_sel = 1'b0;
    target     = seq_pc;
    if (jump_i) begin
      target_sel = 1'b1;
      target     = jump_target_i;
    end else if (branch_i && zero_i) begin
      target_sel = 1'b1;
      target     = branch_target_i;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  assign next_pc_o  = target;
  assign misalign_o = target_sel && !word_aligned(target);
`else
  // Only redirect targets are masked; a misaligned RESET_PC is preserved as-is.
  assign next_pc_o  = target_sel ? (target & 32'hFFFF_FFFC) : target;
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack FSM with timeout, next-PC update on retire.
// Optional FETCH_MISALIGN_CHK_EN turns misaligned branch/jump targets into a sticky error.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_retire,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        bus_err,
  output logic        misalign
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         bus_err_q, bus_err_d;
  logic         misalign_q, misalign_d;
  logic [7:0]   cnt_q, cnt_d;

  logic [31:0]  next_pc;
  logic         tgt_misalign;
  logic         ack_fire;
  logic         timeout_hit;
  logic         retire_fire;

  pc_next_sel u_pc_next_sel (
    .pc_i            (pc_q),
    .branch_i        (branch),
    .zero_i          (zero),
    .jump_i          (jump),
    .branch_target_i (branch_target),
    .jump_target_i   (jump_target),
    .next_pc_o       (next_pc),
    .misalign_o      (tgt_misalign)
  );

  assign ack_fire    = (state_q == S_REQ) && imem_ack;
  assign timeout_hit = (state_q == S_REQ) && !imem_ack && (cnt_q == CNT_LAST);
  assign retire_fire = (state_q == S_EXEC) && valid_q && instr_retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (ack_fire) begin
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_EXEC: begin
        if (retire_fire) begin
          state_d = tgt_misalign ? S_ERR : S_REQ;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Gated by rst_n so no request leaks out while reset is still asserted.
  always_comb begin
    imem_req = (state_q == S_REQ) && rst_n;
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    bus_err_d  = bus_err_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_REQ: begin
        if (ack_fire) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          cnt_d   = 8'd0;
        end else if (timeout_hit) begin
          instr_d   = NOP_INSTR;
          valid_d   = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (retire_fire) begin
          valid_d = 1'b0;
          if (tgt_misalign) begin
            instr_d    = NOP_INSTR;
            misalign_d = 1'b1;
            bus_err_d  = 1'b1;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      default: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign bus_err     = bus_err_q;
  assign misalign    = misalign_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of control_unit.
- Holds the PC and fetches instructions from instruction memory over a req/ack handshake.
- Presents the 32-bit instruction and its PC to decode; instr[6:0] feeds control_unit.opcode.
- On retire, computes the next PC from the branch/jump/zero feedback and starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, max S_REQ cycles without imem_ack before bus error (legal 2..255).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req  out  1  fetch request, high only in S_REQ.
- imem_addr  out  32  fetch address, always equal to pc.
- imem_ack  in  1  memory has valid imem_rdata this cycle; sampled only when imem_req=1.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction to decode.
- instr_valid  out  1  instr/pc_out valid for the current instruction.
- instr_retire  in  1  downstream has finished the instruction; consumed only when instr_valid=1.
- pc_out  out  32  PC of instr.
- pc_plus4  out  32  pc_out+4, wraps mod 2^32; used as link value for JAL.
- branch  in  1  from control_unit.
- zero  in  1  ALU zero flag.
- jump  in  1  from control_unit.
- branch_target  in  32  precomputed branch target.
- jump_target  in  32  precomputed jump target.
- bus_err  out  1  sticky fetch timeout or misalignment error.
- misalign  out  1  sticky misaligned-target flag; tied 0 unless the feature is enabled.

Behaviour:
- Reset values (rst_n low, async, immediate): pc=RESET_PC, state=S_REQ, instr=32'h0000_0013 (NOP), instr_valid=0, bus_err=0, misalign=0, timeout count=0.
- imem_req is combinational: 1 in S_REQ, 0 in every other state, including while rst_n is low.
- States:
  - S_REQ:
    - imem_req=1.
    - imem_ack=1: instr<=imem_rdata, instr_valid<=1, count<=0, goto S_EXEC.
    - No ack: count++; if count==TIMEOUT_CYCLES-1, goto S_ERR with bus_err<=1.
  - S_EXEC:
    - instr_valid=1; instr and pc_out are held stable (stall) while instr_retire=0.
    - instr_retire=1: pc<=next_pc, instr_valid<=0, goto S_REQ.
  - S_ERR:
    - Terminal; instr=NOP, instr_valid=0, imem_req=0.
    - Exit only via reset.
- next_pc priority:
  - jump=1: jump_target.
  - else branch&zero: branch_target.
  - else pc+4.
  - jump and branch both high: jump wins.
- Targets: bits[1:0] are forced to 00 when the feature is disabled.
- Throughput: with zero-wait memory (ack in the first S_REQ cycle), 2 cycles per instruction. Each memory wait state adds 1 cycle.
- Wrap: pc=32'hFFFF_FFFC, sequential retire -> pc=0.
- imem_ack outside S_REQ is ignored.
- instr_retire with instr_valid=0 is ignored.
- Reset mid-fetch: an ack arriving in the same cycle rst_n deasserts is ignored; fetch restarts from RESET_PC.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined: on retire, if the selected target[1:0]!=00 then pc is unchanged, misalign<=1, bus_err<=1, goto S_ERR.
- Undefined: target[1:0] are masked to 00 and misalign is tied 0.

Decomposition:
- Shared package riscv_pkg:
  - opcode localparams (OP_R=7'b0110011, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL).
  - NOP_INSTR=32'h0000_0013.
  - fetch state encoding (S_REQ/S_EXEC/S_ERR).
- One natural sub-module: pc_next_sel (combinational next-PC mux plus alignment mask/check). The FSM and counter stay in the top module.

Test Plan:
- Reset with RESET_PC=32'h100, memory acks every request with 0 wait, retire each cycle instr_valid=1 -> imem_addr sequence 0x100,0x104,0x108; new instruction every 2 cycles; instr matches memory words.
- jump=1 and branch=1 (zero=1), jump_target=0x200, branch_target=0x300, on retire -> next imem_addr=0x200.
- branch=1, zero=0, branch_target=0x300 at pc=0x40 -> next imem_addr=0x44; repeat with zero=1 -> 0x300.
- Hold instr_retire=0 for 5 cycles in S_EXEC -> instr/pc_out stable, imem_req=0; pc=0xFFFF_FFFC sequential retire -> imem_addr=0.
- No imem_ack for 16 cycles -> bus_err=1 after the 16th request cycle, imem_req=0 thereafter; late ack ignored; rst_n pulse -> fetch restarts at RESET_PC.
- With FETCH_MISALIGN_CHK_EN, jump_target=0x202 -> misalign=1, bus_err=1, pc stays unchanged. Without the macro -> fetch proceeds from 0x200.
